// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera capture FIFO
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int LINE_CNT_W      = 10;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead byte FIFO with wrap-bit full/empty
module sync_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cam_capture_fifo.sv
// rtl/cam_capture_fifo.sv - captures one armed camera frame into a FIFO read by the Pico
// Define CAM_LINE_DECIM_EN to store only even lines of the frame.
module cam_capture_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cam_pclk,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_data,
  input  logic                  arm,
  input  logic                  cs_n,
  input  logic                  rd,
  output logic [7:0]            data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  busy,
  output logic                  frame_done,
  output logic [LINE_CNT_W-1:0] line_cnt
);

  localparam int SW = 13;

  // Data rides in the same pipeline as pclk so the sampled byte stays aligned with its edge.
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [7:0]    data_s;
  logic          pclk_s, vsync_s, href_s, cs_n_s, rd_s;
  logic          pclk_prev, vsync_prev, href_prev, rd_prev;
  logic          pclk_rise, vsync_fall, vsync_rise, href_fall, rd_rise;
  logic          keep_line, push, pop;
  cap_state_t    state;

  assign {data_s, pclk_s, vsync_s, href_s, cs_n_s, rd_s} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
      rd_prev    <= 1'b0;
    end else begin
      sync_q[0] <= {cam_data, cam_pclk, cam_vsync, cam_href, cs_n, rd};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pclk_prev  <= pclk_s;
      vsync_prev <= vsync_s;
      href_prev  <= href_s;
      rd_prev    <= rd_s;
    end
  end

  assign pclk_rise  = pclk_s & ~pclk_prev;
  assign vsync_fall = ~vsync_s & vsync_prev;
  assign vsync_rise = vsync_s & ~vsync_prev;
  assign href_fall  = ~href_s & href_prev;
  assign rd_rise    = rd_s & ~rd_prev;

`ifdef CAM_LINE_DECIM_EN
  assign keep_line = ~line_cnt[0];
`else
  assign keep_line = 1'b1;
`endif

  assign push = (state == CAPTURE) && pclk_rise && href_s && keep_line;
  assign pop  = rd_rise && !cs_n_s;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (data_s),
    .dout  (data_out),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      line_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= WAIT_VS;
            busy     <= 1'b1;
            overflow <= 1'b0;
            line_cnt <= '0;
          end
        end
        WAIT_VS: begin
          if (vsync_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          if (push && full && !pop) overflow <= 1'b1;
          if (href_fall && line_cnt != '1) line_cnt <= line_cnt + LINE_CNT_W'(1);
          if (vsync_rise) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_fifo.sv
// tb/tb_cam_capture_fifo.sv - randomized self-checking bench for cam_capture_fifo
module tb_cam_capture_fifo;

  localparam int DEPTH = 8;
`ifdef CAM_LINE_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cam_pclk, cam_vsync, cam_href, arm, cs_n, rd;
  logic [7:0] cam_data, data_out;
  logic       empty, full, overflow, busy, frame_done;
  logic [9:0] line_cnt;

  int total = 0;
  int bad = 0;
  int fd_count = 0;

  byte unsigned mq[$];
  bit           m_ovf;
  bit           m_armed;
  int           m_lines;

  cam_capture_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .arm        (arm),
    .cs_n       (cs_n),
    .rd         (rd),
    .data_out   (data_out),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .busy       (busy),
    .frame_done (frame_done),
    .line_cnt   (line_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void m_push(input byte unsigned b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [7:0] m_head();
    return (mq.size() > 0) ? 8'(mq[0]) : 8'h00;
  endfunction

  task automatic cam_byte(input logic [7:0] b, input bit with_rd);
    cam_data = b;
    cam_pclk = 1'b0;
    tick(4);
    cam_pclk = 1'b1;
    if (with_rd) rd = 1'b1;
    tick(4);
    rd = 1'b0;
  endtask

  task automatic cam_frame(input int lines, input int bpl, input int base, input bit rnd);
    logic [7:0] b;
    cam_vsync = 1'b1; tick(4);
    cam_vsync = 1'b0; tick(6);
    for (int l = 0; l < lines; l++) begin
      cam_href = 1'b1; tick(2);
      for (int i = 0; i < bpl; i++) begin
        b = rnd ? 8'($urandom_range(0, 255)) : 8'(base + l * bpl + i);
        cam_byte(b, 1'b0);
        if (m_armed && (!DECIM || (l % 2) == 0)) m_push(b);
      end
      cam_href = 1'b0; tick(4);
    end
    cam_vsync = 1'b1; tick(8);
    if (m_armed) m_lines = lines;
    m_armed = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(1); arm = 1'b0;
    m_armed = 1'b1; m_ovf = 1'b0; m_lines = 0;
  endtask

  task automatic rd_pulse(input logic c);
    cs_n = c; tick(2);
    rd = 1'b1; tick(3);
    rd = 1'b0; tick(3);
    if (c == 1'b0 && mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    arm = 1'b0; cs_n = 1'b1; rd = 1'b0;
    mq.delete(); m_ovf = 0; m_armed = 0; m_lines = 0;
    tick(3);
    total++; if (data_out !== 8'h00)  begin bad++; $display("FAIL reset_data got=%0h exp=0", data_out); end
    total++; if (empty !== 1'b1)      begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%0b exp=0", frame_done); end
    total++; if (line_cnt !== 10'd0)  begin bad++; $display("FAIL reset_lines got=%0d exp=0", line_cnt); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_no_arm();
    int fd0 = fd_count;
    cam_frame(2, 4, 'h10, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL noarm_empty got=%0b exp=1", empty); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL noarm_busy got=%0b exp=0", busy); end
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL noarm_fd got=%0d exp=0", fd_count - fd0); end
  endtask

  task automatic test_frame();
    int fd0 = fd_count;
    do_arm(); tick(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy got=%0b exp=1", busy); end
    cam_frame(2, 4, 'h10, 1'b0);
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL frame_fd got=%0d exp=1", fd_count - fd0); end
    total++; if (line_cnt !== 10'd2) begin bad++; $display("FAIL frame_lines got=%0d exp=2", line_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_idle got=%0b exp=0", busy); end
    while (mq.size() > 0) begin
      total++; if (data_out !== m_head()) begin bad++; $display("FAIL frame_data got=%0h exp=%0h", data_out, m_head()); end
      rd_pulse(1'b0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL frame_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_overflow();
    int fd0;
    do_arm();
    cam_frame(1, DEPTH + 2, 'h40, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b exp=1", full); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag got=%0b exp=%0b", overflow, m_ovf); end
    while (mq.size() > 0) begin
      total++; if (data_out !== m_head()) begin bad++; $display("FAIL ovf_data got=%0h exp=%0h", data_out, m_head()); end
      rd_pulse(1'b0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%0b exp=1", empty); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    fd0 = fd_count;
    do_arm();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    cam_frame(0, 0, 0, 1'b0);
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL nohref_fd got=%0d exp=1", fd_count - fd0); end
    total++; if (line_cnt !== 10'd0) begin bad++; $display("FAIL nohref_lines got=%0d exp=0", line_cnt); end
  endtask

  task automatic test_simul();
    do_arm();
    cs_n = 1'b0;
    cam_vsync = 1'b1; tick(4);
    cam_vsync = 1'b0; tick(6);
    cam_href = 1'b1; tick(2);
    for (int i = 0; i < DEPTH; i++) begin
      cam_byte(8'(8'h80 + i), 1'b0);
      m_push(8'(8'h80 + i));
    end
    cam_byte(8'hab, 1'b1);
    void'(mq.pop_front());
    m_push(8'hab);
    cam_href = 1'b0; tick(4);
    cam_vsync = 1'b1; tick(8);
    m_armed = 1'b0; m_lines = 1;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL simul_ovf got=%0b exp=0", overflow); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL simul_full got=%0b exp=1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (data_out !== m_head()) begin bad++; $display("FAIL simul_data got=%0h exp=%0h", data_out, m_head()); end
      rd_pulse(1'b0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_no_pop();
    do_arm();
    cam_frame(1, 3, 'h60, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd_pulse(1'b1);
      total++; if (data_out !== m_head()) begin bad++; $display("FAIL nocs_data got=%0h exp=%0h", data_out, m_head()); end
    end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL nocs_empty got=%0b exp=0", empty); end
    while (mq.size() > 0) rd_pulse(1'b0);
    rd_pulse(1'b0);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL popempty_data got=%0h exp=0", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL popempty_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL popempty_full got=%0b exp=0", full); end
  endtask

  task automatic test_reset_mid();
    do_arm();
    cam_vsync = 1'b1; tick(4);
    cam_vsync = 1'b0; tick(6);
    cam_href = 1'b1; tick(2);
    cam_byte(8'h21, 1'b0);
    cam_byte(8'h22, 1'b0);
    cam_href = 1'b0; tick(4);
    cam_href = 1'b1; tick(2);
    cam_byte(8'h23, 1'b0);
    tick(4);
    total++; if (line_cnt !== 10'd1) begin bad++; $display("FAIL mid_lines got=%0d exp=1", line_cnt); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL mid_empty got=%0b exp=0", empty); end
    rst = 1'b1;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%0b exp=1", empty); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    total++; if (line_cnt !== 10'd0) begin bad++; $display("FAIL rstmid_lines got=%0d exp=0", line_cnt); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%0h exp=0", data_out); end
    cam_href = 1'b0; cam_vsync = 1'b1;
    mq.delete(); m_ovf = 0; m_armed = 0; m_lines = 0;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_four_lines();
    int n = 0;
    int exp_n = DECIM ? 4 : 8;
    do_arm();
    cam_frame(4, 2, 'h70, 1'b0);
    total++; if (line_cnt !== 10'd4) begin bad++; $display("FAIL four_lines got=%0d exp=4", line_cnt); end
    while (empty === 1'b0 && n < 16) begin
      total++; if (data_out !== m_head()) begin bad++; $display("FAIL four_data got=%0h exp=%0h", data_out, m_head()); end
      rd_pulse(1'b0);
      n++;
    end
    total++; if (n !== exp_n) begin bad++; $display("FAIL four_count got=%0d exp=%0d", n, exp_n); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int lines = $urandom_range(0, 4);
      int bpl = $urandom_range(1, 5);
      bit a = ($urandom_range(0, 4) != 0);
      int nrd = $urandom_range(0, 6);
      int fd0 = fd_count;
      if (a) do_arm();
      cam_frame(lines, bpl, 0, 1'b1);
      total++; if (fd_count - fd0 !== int'(a)) begin bad++; $display("FAIL rnd_fd got=%0d exp=%0d", fd_count - fd0, a); end
      total++; if (line_cnt !== 10'(m_lines)) begin bad++; $display("FAIL rnd_lines got=%0d exp=%0d", line_cnt, m_lines); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf got=%0b exp=%0b", overflow, m_ovf); end
      total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty got=%0b exp=%0d", empty, mq.size() == 0); end
      total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full got=%0b exp=%0d", full, mq.size() == DEPTH); end
      for (int k = 0; k < nrd; k++) begin
        rd_pulse(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        total++; if (data_out !== m_head()) begin bad++; $display("FAIL rnd_data got=%0h exp=%0h", data_out, m_head()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_arm();
    test_frame();
    test_overflow();
    test_simul();
    test_no_pop();
    test_reset_mid();
    test_four_lines();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
